piso_8bit_asynch_clr: RTL and testbench

PISO_8BIT_ASYNCH_CLR -- requirements
Module: piso_8bit_asynch_clr

---
 rtl/piso_8bit_asynch_clr.sv | 120 ++++++++++++
 tb/tb_piso_8bit_asynch_clr.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_8bit_asynch_clr.sv
`default_nettype none
// ============================================================================
//  Module   : piso_8bit_asynch_clr
//  Purpose  : 8-bit parallel-in / serial-out shifter. An accepted load
//             captures D and streams its eight bits on Sout, each held for
//             BIT_CYCLES clocks, then pulses Done for one cycle back in idle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MSB_FIRST  : 1 sends D[7] first, 0 sends D[0] first
//    BIT_CYCLES : clocks per bit on Sout, legal range 1..16
//  Ports
//    CLK        : in  - clock, all state changes on rising edge
//    Asynch_clr : in  - asynchronous active-high clear
//    D[7:0]     : in  - parallel byte, sampled only on an accepted load
//    Load       : in  - load request, accepted when Ready=1
//    Ready      : out - idle, a load will be accepted
//    Sout       : out - serial data (0 while idle)
//    Sout_valid : out - Sout carries a frame bit
//    Done       : out - one-cycle pulse in the first idle cycle after a frame
// ============================================================================
module piso_8bit_asynch_clr #(
    parameter int MSB_FIRST  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       Asynch_clr,
    input  logic [7:0] D,
    input  logic       Load,
    output logic       Ready,
    output logic       Sout,
    output logic       Sout_valid,
    output logic       Done
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    // Terminal value of the per-bit cycle counter; BIT_CYCLES=16 gives 15,
    // so the 4-bit counter runs its full range before wrapping.
    localparam logic [3:0] c_LAST_CYC = 4'(BIT_CYCLES - 1);

    logic [0:0] r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_cyc_cnt;

    logic [7:0] w_shifted;
    logic       w_last_cyc;
    logic       w_last_bit;

    // The outgoing bit always sits at the exit end of the shift register, so
    // Sout is a plain register bit. The register is cleared whenever the
    // block is idle, which keeps Sout at 0 outside a frame.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_shreg[6:0], 1'b0};
            assign Sout      = r_shreg[7];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[7:1]};
            assign Sout      = r_shreg[0];
        end
    endgenerate

    assign w_last_cyc = (r_cyc_cnt == c_LAST_CYC);
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge CLK or posedge Asynch_clr) begin
        if (Asynch_clr) begin
            r_state    <= c_IDLE;
            r_shreg    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_cyc_cnt  <= 4'd0;
            Ready      <= 1'b1;
            Sout_valid <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Done only lives for the first idle cycle; a load in
                    // that same cycle is accepted as usual.
                    Done <= 1'b0;
                    if (Load) begin
                        r_shreg    <= D;
                        r_bit_cnt  <= 3'd0;
                        r_cyc_cnt  <= 4'd0;
                        Ready      <= 1'b0;
                        Sout_valid <= 1'b1;
                        r_state    <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    // Load is deliberately not examined here: requests
                    // during a frame are dropped, not queued.
                    if (w_last_cyc) begin
                        r_cyc_cnt <= 4'd0;
                        if (w_last_bit) begin
                            r_shreg    <= 8'h00;
                            r_bit_cnt  <= 3'd0;
                            Ready      <= 1'b1;
                            Sout_valid <= 1'b0;
                            Done       <= 1'b1;
                            r_state    <= c_IDLE;
                        end else begin
                            r_shreg   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_8bit_asynch_clr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_8bit_asynch_clr
//  Purpose  : Self-checking bench for piso_8bit_asynch_clr. Three instances
//             (MSB/1 cycle, LSB/4 cycles, MSB/16 cycles) share the stimulus;
//             every cycle their outputs are compared with a frame-position
//             reference model, plus directed frame-level checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_8bit_asynch_clr;

    logic       CLK        = 1'b0;
    logic       Asynch_clr = 1'b0;
    logic       Load       = 1'b0;
    logic [7:0] D          = 8'h00;

    logic [2:0] rdy;
    logic [2:0] so;
    logic [2:0] sv;
    logic [2:0] dn;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    piso_8bit_asynch_clr #(.MSB_FIRST(1), .BIT_CYCLES(1)) u_dut0 (
        .CLK(CLK), .Asynch_clr(Asynch_clr), .D(D), .Load(Load),
        .Ready(rdy[0]), .Sout(so[0]), .Sout_valid(sv[0]), .Done(dn[0]));

    piso_8bit_asynch_clr #(.MSB_FIRST(0), .BIT_CYCLES(4)) u_dut1 (
        .CLK(CLK), .Asynch_clr(Asynch_clr), .D(D), .Load(Load),
        .Ready(rdy[1]), .Sout(so[1]), .Sout_valid(sv[1]), .Done(dn[1]));

    piso_8bit_asynch_clr #(.MSB_FIRST(1), .BIT_CYCLES(16)) u_dut2 (
        .CLK(CLK), .Asynch_clr(Asynch_clr), .D(D), .Load(Load),
        .Ready(rdy[2]), .Sout(so[2]), .Sout_valid(sv[2]), .Done(dn[2]));

    function automatic int bc_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    endfunction

    function automatic bit msb_of(input int k);
        return (k != 1);
    endfunction

    // Reference model: position within the frame (-1 = idle), the byte being
    // sent, and whether this is the Done cycle.
    int         m_pos  [3];
    logic [7:0] m_byte [3];
    logic       m_done [3];

    always @(posedge CLK or posedge Asynch_clr) begin
        for (int k = 0; k < 3; k++) begin
            if (Asynch_clr) begin
                m_pos[k]  <= -1;
                m_byte[k] <= 8'h00;
                m_done[k] <= 1'b0;
            end else if (m_pos[k] < 0) begin
                m_done[k] <= 1'b0;
                if (Load) begin
                    m_byte[k] <= D;
                    m_pos[k]  <= 0;
                end
            end else if (m_pos[k] + 1 == 8 * bc_of(k)) begin
                m_pos[k]  <= -1;
                m_done[k] <= 1'b1;
            end else begin
                m_pos[k] <= m_pos[k] + 1;
            end
        end
    end

    function automatic logic exp_sout(input int k);
        int idx;
        if (m_pos[k] < 0) return 1'b0;
        idx = m_pos[k] / bc_of(k);
        return msb_of(k) ? m_byte[k][7 - idx] : m_byte[k][idx];
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.rdy%0d", tag, k), int'(rdy[k]), int'(m_pos[k] < 0));
            chk($sformatf("%s.sv%0d", tag, k), int'(sv[k]), int'(m_pos[k] >= 0));
            chk($sformatf("%s.so%0d", tag, k), int'(so[k]), int'(exp_sout(k)));
            chk($sformatf("%s.dn%0d", tag, k), int'(dn[k]), int'(m_done[k]));
        end
    endtask

    // Inputs change just after a falling edge; outputs are checked at the
    // next falling edge, half a period after the rising edge that used them.
    task automatic step(input logic ld, input logic [7:0] d, input string tag);
        Load = ld;
        D    = d;
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic do_reset();
        Load       = 1'b0;
        Asynch_clr = 1'b1;
        @(negedge CLK);
        chk("reset.rdy", int'(rdy), 7);
        chk("reset.sv",  int'(sv),  0);
        chk("reset.so",  int'(so),  0);
        chk("reset.dn",  int'(dn),  0);
        Asynch_clr = 1'b0;
    endtask

    // Clear pulse placed strictly between clock edges.
    task automatic pulse_clr(input string tag);
        #2 Asynch_clr = 1'b1;
        #1;
        chk({tag, ".rdy"}, int'(rdy), 7);
        chk({tag, ".sv"},  int'(sv),  0);
        chk({tag, ".so"},  int'(so),  0);
        chk({tag, ".dn"},  int'(dn),  0);
        #1 Asynch_clr = 1'b0;
        @(negedge CLK);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] acc;
        logic [7:0] dcur;
        int         n_done;
        int         n_idle;
        int         n_valid;
        int         n_bad;
        logic [7:0] frames [$];

        #1 Asynch_clr = 1'b1;
        @(negedge CLK);
        Asynch_clr = 1'b0;

        // A5, MSB first, one cycle per bit
        do_reset();
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) step(1'b1, 8'hA5, "a5");
            else        step(1'b0, 8'h00, "a5");
            chk("a5.valid", int'(sv[0]), 1);
            acc = {acc[6:0], so[0]};
        end
        chk("a5.byte", int'(acc), 8'hA5);
        step(1'b0, 8'h00, "a5.end");
        chk("a5.done", int'(dn[0]), 1);
        chk("a5.ready", int'(rdy[0]), 1);
        step(1'b0, 8'h00, "a5.after");
        chk("a5.done_once", int'(dn[0]), 0);

        // 81, LSB first, four cycles per bit
        do_reset();
        n_bad   = 0;
        n_valid = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) step(1'b1, 8'h81, "x81");
            else        step(1'b0, 8'h00, "x81");
            if (sv[1]) n_valid++;
            if (so[1] !== ((i < 4) || (i >= 28))) n_bad++;
        end
        chk("x81.valid_cycles", n_valid, 32);
        chk("x81.pattern_bad", n_bad, 0);
        step(1'b0, 8'h00, "x81.end");
        chk("x81.done", int'(dn[1]), 1);

        // Load held high, next byte presented on each Done cycle
        do_reset();
        dcur   = 8'h3C;
        acc    = 8'h00;
        n_idle = 0;
        frames.delete();
        for (int i = 0; i < 27; i++) begin
            step(1'b1, dcur, "b2b");
            if (sv[0]) acc = {acc[6:0], so[0]};
            if (rdy[0]) n_idle++;
            if (dn[0]) begin
                frames.push_back(acc);
                dcur = 8'hC3;
            end
        end
        chk("b2b.idle_cycles", n_idle, 3);
        chk("b2b.frames", frames.size(), 3);
        if (frames.size() == 3) begin
            chk("b2b.frame0", int'(frames[0]), 8'h3C);
            chk("b2b.frame1", int'(frames[1]), 8'hC3);
            chk("b2b.frame2", int'(frames[2]), 8'hC3);
        end

        // Load during the third bit of a 00 frame is dropped
        do_reset();
        acc    = 8'h00;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      step(1'b1, 8'h00, "drop");
            else if (i == 2) step(1'b1, 8'hFF, "drop");
            else             step(1'b0, 8'h00, "drop");
            if (i < 8) acc = acc | {7'b0, so[0]};
            if (dn[0]) n_done++;
        end
        chk("drop.any_one", int'(acc), 0);
        chk("drop.done_count", n_done, 1);

        // Clear between edges during bit 5 aborts the frame silently
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 8'h5A, "abort");
            else        step(1'b0, 8'h00, "abort");
        end
        chk("abort.mid_valid", int'(sv[0]), 1);
        pulse_clr("abort.clr");
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, "abort.after");
            if (dn[0]) n_done++;
        end
        chk("abort.no_done", n_done, 0);

        // Load while clear is high is ignored
        Load       = 1'b1;
        D          = 8'h77;
        Asynch_clr = 1'b1;
        @(negedge CLK);
        Asynch_clr = 1'b0;
        Load       = 1'b0;
        @(negedge CLK);
        check_all("clrload");
        chk("clrload.idle", int'(rdy[0]), 1);
        step(1'b1, 8'h77, "clrload.first");
        chk("clrload.accepted", int'(sv[0]), 1);

        // 01, MSB first, sixteen cycles per bit
        do_reset();
        n_bad   = 0;
        n_valid = 0;
        for (int i = 0; i < 128; i++) begin
            if (i == 0) step(1'b1, 8'h01, "x01");
            else        step(1'b0, 8'h00, "x01");
            if (sv[2]) n_valid++;
            if (so[2] !== (i >= 112)) n_bad++;
        end
        chk("x01.valid_cycles", n_valid, 128);
        chk("x01.pattern_bad", n_bad, 0);
        step(1'b0, 8'h00, "x01.end");
        chk("x01.done", int'(dn[2]), 1);

        // Randomized traffic with occasional mid-cycle clears
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), "rand");
            if ($urandom_range(0, 79) == 0) pulse_clr("rand.clr");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
